// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for a multicycle MIPS-subset datapath. It sequences each
// instruction through IF/ID/EXE/MEM/WB, decodes op/func into datapath
// enables and selects, stops in HALT on HALT_OP, and counts instructions
// that complete (every cycle that writes the PC).
//
// Parameters
//   HALT_OP  opcode that stops sequencing
//   W_CNT    width of the retired-instruction counter
//
// Ports
//   CLK        in   rising-edge clock
//   Reset      in   synchronous, active-low reset
//   op, func   in   opcode / function field from the instruction register
//   Zero       in   ALU zero flag (branch decision)
//   mem_ready  in   data memory access complete
//   PCWre, IRWre, MemWr, MemRd, RegWr        out  datapath enables
//   RegDst, MemtoReg, ALUsrc, ExtOp          out  datapath selects
//   PCSrc[1:0] out  00 PC+4, 01 branch target, 10 jump target
//   ALUop[2:0] out  000 add, 001 sub, 010 and, 011 or, 100 slt
//   state[2:0] out  current FSM state
//   halted     out  HALT state reached (registered)
//   illegal    out  one-cycle pulse in ID on an undefined op/func
//   retired    out  completed-instruction count, wraps modulo 2^W_CNT
// ---------------------------------------------------------------------------
module multicycle_controller #(
  parameter logic [5:0] HALT_OP = 6'b111111,
  parameter int         W_CNT   = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWre,
  output logic             IRWre,
  output logic             MemWr,
  output logic             MemRd,
  output logic             RegWr,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             ALUsrc,
  output logic             ExtOp,
  output logic [1:0]       PCSrc,
  output logic [2:0]       ALUop,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [W_CNT-1:0] retired
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t st;
  state_t nxt;

  logic       is_r, is_addi, is_ori, is_lw, is_sw, is_beq, is_j, is_halt;
  logic       r_ok;
  logic [2:0] r_aluop;
  logic       op_ok;

  assign is_r    = (op == 6'b000000);
  assign is_addi = (op == 6'b001000);
  assign is_ori  = (op == 6'b001101);
  assign is_lw   = (op == 6'b100011);
  assign is_sw   = (op == 6'b101011);
  assign is_beq  = (op == 6'b000100);
  assign is_j    = (op == 6'b000010);
  assign is_halt = (op == HALT_OP);

  // R-type function decode; an unknown func makes the whole instruction illegal
  always_comb begin
    r_ok    = 1'b1;
    r_aluop = 3'b000;
    case (func)
      6'b100000: r_aluop = 3'b000;
      6'b100010: r_aluop = 3'b001;
      6'b100100: r_aluop = 3'b010;
      6'b100101: r_aluop = 3'b011;
      6'b101010: r_aluop = 3'b100;
      default:   r_ok    = 1'b0;
    endcase
    op_ok = (is_r & r_ok) | is_addi | is_ori | is_lw | is_sw |
            is_beq | is_j | is_halt;
  end

  // Combinational output decode and next-state. With Reset low every
  // output stays at its zero default.
  always_comb begin
    PCWre    = 1'b0;
    IRWre    = 1'b0;
    MemWr    = 1'b0;
    MemRd    = 1'b0;
    RegWr    = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUsrc   = 1'b0;
    ExtOp    = 1'b0;
    PCSrc    = 2'b00;
    ALUop    = 3'b000;
    illegal  = 1'b0;
    nxt      = st;
    if (Reset) begin
      case (st)
        S_IF: begin
          IRWre = 1'b1;
          nxt   = S_ID;
        end
        S_ID: begin
          if (is_j) begin
            PCWre = 1'b1;
            PCSrc = 2'b10;
            nxt   = S_IF;
          end else if (is_halt) begin
            nxt = S_HALT;
          end else if (!op_ok) begin
            // skip the undefined instruction: count it and fetch PC+4
            illegal = 1'b1;
            PCWre   = 1'b1;
            nxt     = S_IF;
          end else begin
            nxt = S_EXE;
          end
        end
        S_EXE: begin
          if (is_r) begin
            ALUop = r_aluop;
          end else if (is_addi | is_lw | is_sw) begin
            ALUsrc = 1'b1;
            ExtOp  = 1'b1;
          end else if (is_ori) begin
            ALUsrc = 1'b1;
            ALUop  = 3'b011;
          end else if (is_beq) begin
            ALUop = 3'b001;
          end
          if (is_beq) begin
            PCWre = 1'b1;
            PCSrc = {1'b0, Zero};
            nxt   = S_IF;
          end else if (is_lw | is_sw) begin
            nxt = S_MEM;
          end else begin
            nxt = S_WB;
          end
        end
        S_MEM: begin
          // strobes held for the whole access, including the ready cycle
          MemRd = is_lw;
          MemWr = is_sw;
          if (mem_ready) begin
            if (is_sw) begin
              PCWre = 1'b1;
              nxt   = S_IF;
            end else begin
              nxt = S_WB;
            end
          end
        end
        S_WB: begin
          RegWr    = 1'b1;
          PCWre    = 1'b1;
          RegDst   = is_r;
          MemtoReg = is_lw;
          nxt      = S_IF;
        end
        S_HALT: nxt = S_HALT;
        default: nxt = S_IF;
      endcase
    end
  end

  // State, halted flag and retired counter
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      st      <= S_IF;
      halted  <= 1'b0;
      retired <= '0;
    end else begin
      st     <= nxt;
      halted <= (nxt == S_HALT);
      if (PCWre)
        retired <= retired + {{(W_CNT-1){1'b0}}, 1'b1};
    end
  end

  assign state = st;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed bench for multicycle_controller (W_CNT = 4 so the retired counter
// wrap is reachable). Inputs change 1 ns after the rising edge; outputs are
// sampled 2 ns after the edge. Control outputs are compared as one packed
// vector {PCWre,IRWre,MemWr,MemRd,RegWr,RegDst,MemtoReg,ALUsrc,ExtOp,
// PCSrc,ALUop,illegal}.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] op;
  logic [5:0] func;
  logic       Zero;
  logic       mem_ready;
  logic       PCWre, IRWre, MemWr, MemRd, RegWr, RegDst, MemtoReg, ALUsrc, ExtOp;
  logic [1:0] PCSrc;
  logic [2:0] ALUop;
  logic [2:0] state;
  logic       halted;
  logic       illegal;
  logic [3:0] retired;

  int n_checks = 0;
  int n_err    = 0;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  multicycle_controller #(.HALT_OP(6'b111111), .W_CNT(4)) dut (
    .CLK(CLK), .Reset(Reset), .op(op), .func(func), .Zero(Zero),
    .mem_ready(mem_ready), .PCWre(PCWre), .IRWre(IRWre), .MemWr(MemWr),
    .MemRd(MemRd), .RegWr(RegWr), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUsrc(ALUsrc), .ExtOp(ExtOp), .PCSrc(PCSrc), .ALUop(ALUop),
    .state(state), .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 CLK = ~CLK;

  function automatic logic [14:0] ctl(input logic pcw, irw, mw, mr, rw, rd,
                                      m2r, as, ex, input logic [1:0] ps,
                                      input logic [2:0] ao, input logic il);
    return {pcw, irw, mw, mr, rw, rd, m2r, as, ex, ps, ao, il};
  endfunction

  localparam logic [14:0] NONE = 15'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // check state and control vector for the current cycle, then advance
  task automatic step(input string tag, input logic [2:0] exp_state,
                      input logic [14:0] exp_ctl);
    #1;
    chk({tag, "_state"}, {29'd0, state}, {29'd0, exp_state});
    chk({tag, "_ctl"},
        {17'd0, PCWre, IRWre, MemWr, MemRd, RegWr, RegDst, MemtoReg, ALUsrc,
         ExtOp, PCSrc, ALUop, illegal},
        {17'd0, exp_ctl});
    tick();
  endtask

  localparam logic [14:0] C_IF = 15'b0_1_0_0_0_0_0_0_0_00_000_0;

  initial begin
    Reset = 1'b0; op = OP_J; func = 6'd0; Zero = 1'b0; mem_ready = 1'b0;
    repeat (2) tick();
    #1;
    chk("rst_state",   {29'd0, state},   32'd0);
    chk("rst_halted",  {31'd0, halted},  32'd0);
    chk("rst_retired", {28'd0, retired}, 32'd0);
    chk("rst_ctl", {17'd0, PCWre, IRWre, MemWr, MemRd, RegWr, RegDst, MemtoReg,
                    ALUsrc, ExtOp, PCSrc, ALUop, illegal}, 32'd0);
    Reset = 1'b1;

    // R-type add: 0,1,2,4,0
    op = OP_R; func = 6'b100000;
    step("add_if",  3'd0, C_IF);
    step("add_id",  3'd1, NONE);
    step("add_exe", 3'd2, NONE);
    chk("add_ret_before", {28'd0, retired}, 32'd0);
    step("add_wb",  3'd4, ctl(1,0,0,0,1,1,0,0,0,2'b00,3'b000,0));
    chk("add_ret_after",  {28'd0, retired}, 32'd1);

    // R-type sub: ALUop from func
    func = 6'b100010;
    step("sub_if",  3'd0, C_IF);
    step("sub_id",  3'd1, NONE);
    step("sub_exe", 3'd2, ctl(0,0,0,0,0,0,0,0,0,2'b00,3'b001,0));
    step("sub_wb",  3'd4, ctl(1,0,0,0,1,1,0,0,0,2'b00,3'b000,0));
    chk("sub_ret", {28'd0, retired}, 32'd2);

    // beq taken then not taken, 3 cycles each
    op = OP_BEQ; Zero = 1'b1;
    step("beqt_if",  3'd0, C_IF);
    step("beqt_id",  3'd1, NONE);
    step("beqt_exe", 3'd2, ctl(1,0,0,0,0,0,0,0,0,2'b01,3'b001,0));
    chk("beqt_ret", {28'd0, retired}, 32'd3);
    Zero = 1'b0;
    step("beqn_if",  3'd0, C_IF);
    step("beqn_id",  3'd1, NONE);
    step("beqn_exe", 3'd2, ctl(1,0,0,0,0,0,0,0,0,2'b00,3'b001,0));
    chk("beqn_ret", {28'd0, retired}, 32'd4);

    // ori: zero-extend, or
    op = OP_ORI;
    step("ori_if",  3'd0, C_IF);
    step("ori_id",  3'd1, NONE);
    step("ori_exe", 3'd2, ctl(0,0,0,0,0,0,0,1,0,2'b00,3'b011,0));
    step("ori_wb",  3'd4, ctl(1,0,0,0,1,0,0,0,0,2'b00,3'b000,0));
    chk("ori_ret", {28'd0, retired}, 32'd5);

    // lw with 3 wait cycles: 8 cycles total
    op = OP_LW; mem_ready = 1'b0;
    step("lw_if",  3'd0, C_IF);
    step("lw_id",  3'd1, NONE);
    step("lw_exe", 3'd2, ctl(0,0,0,0,0,0,0,1,1,2'b00,3'b000,0));
    for (int i = 0; i < 3; i++)
      step("lw_memwait", 3'd3, ctl(0,0,0,1,0,0,0,0,0,2'b00,3'b000,0));
    mem_ready = 1'b1;
    step("lw_memrdy", 3'd3, ctl(0,0,0,1,0,0,0,0,0,2'b00,3'b000,0));
    mem_ready = 1'b0;
    step("lw_wb", 3'd4, ctl(1,0,0,0,1,0,1,0,0,2'b00,3'b000,0));
    #1;
    chk("lw_done_state", {29'd0, state},   32'd0);
    chk("lw_ret",        {28'd0, retired}, 32'd6);

    // sw interrupted by reset on its second MEM cycle
    op = OP_SW;
    step("sw_if",   3'd0, C_IF);
    step("sw_id",   3'd1, NONE);
    step("sw_exe",  3'd2, ctl(0,0,0,0,0,0,0,1,1,2'b00,3'b000,0));
    step("sw_mem1", 3'd3, ctl(0,0,1,0,0,0,0,0,0,2'b00,3'b000,0));
    Reset = 1'b0;
    step("sw_mem2_rst", 3'd3, NONE);
    Reset = 1'b1;
    #1;
    chk("sw_rst_state",   {29'd0, state},   32'd0);
    chk("sw_rst_retired", {28'd0, retired}, 32'd0);
    chk("sw_rst_memwr",   {31'd0, MemWr},   32'd0);

    // undefined opcode: skipped and counted
    op = 6'b111110;
    step("ill_if", 3'd0, C_IF);
    step("ill_id", 3'd1, ctl(1,0,0,0,0,0,0,0,0,2'b00,3'b000,1));
    chk("ill_ret", {28'd0, retired}, 32'd1);

    // undefined R-type func
    op = OP_R; func = 6'b000001;
    step("illf_if", 3'd0, C_IF);
    step("illf_id", 3'd1, ctl(1,0,0,0,0,0,0,0,0,2'b00,3'b000,1));
    chk("illf_ret", {28'd0, retired}, 32'd2);

    // HALT: held 20 cycles, not counted
    op = 6'b111111;
    step("halt_if", 3'd0, C_IF);
    step("halt_id", 3'd1, NONE);
    op = OP_J;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("halt_halted",  {31'd0, halted},  32'd1);
      chk("halt_retired", {28'd0, retired}, 32'd2);
      #1;
      step("halt_hold", 3'd5, NONE);
    end
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    #1;
    chk("halt_rst_halted",  {31'd0, halted},  32'd0);
    chk("halt_rst_state",   {29'd0, state},   32'd0);
    chk("halt_rst_retired", {28'd0, retired}, 32'd0);

    // 16 jumps: retired climbs to 15 then wraps to 0
    op = OP_J;
    for (int i = 0; i < 16; i++) begin
      step("j_if", 3'd0, C_IF);
      step("j_id", 3'd1, ctl(1,0,0,0,0,0,0,0,0,2'b10,3'b000,0));
      chk("j_retired", {28'd0, retired}, 32'((i + 1) % 16));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter HALT_OP, default 6'b111111, which is the opcode that stops sequencing.
REQ-002 SHALL have parameter W_CNT, default 32, which is the width of the retired-instruction counter.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port op, input, 6 bits: opcode from the instruction register.
REQ-006 SHALL have port func, input, 6 bits: function field from the instruction register.
REQ-007 SHALL have port Zero, input, 1 bit: ALU zero flag.
REQ-008 SHALL have port mem_ready, input, 1 bit: data memory access complete.
REQ-009 SHALL have outputs PCWre, IRWre, MemWr, MemRd, RegWr, RegDst, MemtoReg, ALUsrc and ExtOp, each 1 bit, as datapath enables and selects.
REQ-010 SHALL have output PCSrc, 2 bits: next-PC select (00 = PC+4, 01 = branch target, 10 = jump target).
REQ-011 SHALL have output ALUop, 3 bits: 000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-012 SHALL have output state, 3 bits: current FSM state.
REQ-013 SHALL have output halted, 1 bit: HALT state reached.
REQ-014 SHALL have output illegal, 1 bit: one-cycle pulse on an undefined opcode.
REQ-015 SHALL have output retired, W_CNT bits: count of completed instructions.

Function
REQ-016 SHALL use the state encoding IF = 0, ID = 1, EXE = 2, MEM = 3, WB = 4, HALT = 5; codes 6 and 7 SHALL go to IF on the next edge.
REQ-017 SHALL decode op as follows: R-type 000000, addi 001000, ori 001101, lw 100011, sw 101011, beq 000100, j 000010, and HALT_OP; any other op is undefined.
REQ-018 SHALL decode R-type func as follows: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other func is treated as undefined.
REQ-019 SHALL make all outputs except state, halted and retired combinational decodes of state, op, func and Zero; every enable not listed for a state SHALL be 0.
REQ-020 In IF, SHALL assert IRWre = 1 and go to ID.
REQ-021 In ID, with j: SHALL assert PCWre = 1 and PCSrc = 10, and go to IF.
REQ-022 In ID, with HALT_OP: SHALL go to HALT with no PC write.
REQ-023 In ID, with an undefined op or func: SHALL assert illegal, PCWre = 1 and PCSrc = 00, and go to IF.
REQ-024 In ID, with any other op: SHALL go to EXE.
REQ-025 In EXE, ALU controls SHALL be:
- R-type: ALUsrc = 0, ALUop from func.
- addi, lw, sw: ALUsrc = 1, ExtOp = 1, ALUop = 000.
- ori: ALUsrc = 1, ExtOp = 0, ALUop = 011.
- beq: ALUsrc = 0, ALUop = 001.
REQ-026 In EXE, with beq: SHALL assert PCWre = 1 and PCSrc = {0, Zero}, and go to IF.
REQ-027 In EXE, with lw or sw: SHALL go to MEM.
REQ-028 In EXE, with R-type, addi or ori: SHALL go to WB.
REQ-029 In MEM, lw SHALL hold MemRd = 1 and sw SHALL hold MemWr = 1 for every cycle until mem_ready = 1, staying in MEM while mem_ready = 0, with no timeout.
REQ-030 In MEM, on mem_ready = 1: sw SHALL assert PCWre = 1 and PCSrc = 00 and go to IF; lw SHALL go to WB.
REQ-031 In WB, SHALL assert RegWr = 1, PCWre = 1 and PCSrc = 00, with RegDst = 1 for R-type else 0, and MemtoReg = 1 for lw else 0; then go to IF.
REQ-032 In HALT, SHALL hold halted = 1 with all enables 0, and stay in HALT until reset.
REQ-033 SHALL increment retired by 1 on every edge where PCWre = 1, including illegal skips, wrapping modulo 2^W_CNT.
REQ-034 SHALL not count a HALT instruction in retired.
REQ-035 SHALL give these latencies in cycles: j 2; beq 3; R-type, addi and ori 4; sw 4 + wait cycles; lw 5 + wait cycles.

Reset
REQ-036 When Reset = 0 at a rising CLK, SHALL set state = IF, halted = 0 and retired = 0, regardless of the current state, including in MEM mid-access or in HALT.
REQ-037 While Reset = 0, SHALL force PCWre, IRWre, MemWr, MemRd, RegWr and illegal to 0.
REQ-038 While Reset = 0, SHALL force PCSrc = 00, ALUop = 000, and all selects to 0.
REQ-039 On the first edge with Reset = 1, SHALL start in IF with IRWre = 1.

Verification
REQ-040 Bench SHALL cover: R-type add (op 000000, func 100000) -> states 0,1,2,4,0, RegWr = 1 and RegDst = 1 in WB only, retired 0 -> 1.
REQ-041 Bench SHALL cover: beq with Zero = 1, then with Zero = 0 -> 3 cycles each, PCSrc = 01 then 00 in EXE, PCWre = 1 once each, RegWr never 1.
REQ-042 Bench SHALL cover: lw with mem_ready low for 3 cycles -> MEM held 4 cycles with MemRd = 1, then WB with MemtoReg = 1, total 8 cycles.
REQ-043 Bench SHALL cover: sw, with Reset driven low on the second MEM cycle -> next state IF, MemWr = 0, retired = 0.
REQ-044 Bench SHALL cover: op 111110 -> illegal pulse in ID, PCSrc = 00, retired + 1; then op 111111 -> halted = 1 held for 20 cycles and retired unchanged.
REQ-045 Bench SHALL cover: j with W_CNT = 4 and retired = 15 -> PCSrc = 10 in ID, retired wraps to 0.
